lfsr_checker: RTL and testbench

//  Receive end of the pseudorandom LFSR link: consumes the parallel state words emitted by the

---
 rtl/lfsr_checker.sv | 138 +++++++++++++
 tb/tb_lfsr_checker.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/lfsr_checker.sv
// Receive-side LFSR checker. It first locks onto the incoming sequence by
// reseeding from the line. Once locked it runs its own LFSR as a flywheel,
// then flags and counts any received word that differs from its prediction.
//
//   state  | meaning
//   -------+------------------------------------------------------------
//   HUNT   | reseeding from din each valid sample, counting good predictions
//   LOCKED | flywheel prediction, mismatches pulse/count, LOSS_CNT misses drop
module lfsr_checker #(
    parameter int               WIDTH    = 4,
    parameter logic [WIDTH-1:0] TAPS     = 4'b1100,
    parameter int               LOCK_CNT = 3,
    parameter int               LOSS_CNT = 3,
    parameter int               CNT_W    = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    input  logic             clr_err,
    output logic             locked,
    output logic             err_pulse,
    output logic [CNT_W-1:0] err_count,
    output logic             zero_seen
);

    localparam int MATCH_W = $clog2(LOCK_CNT + 1);
    localparam int MISS_W  = $clog2(LOSS_CNT + 1);

    typedef enum logic {
        HUNT,
        LOCKED
    } state_t;

    state_t             state, state_n;
    logic [WIDTH-1:0]   pred, pred_n;
    logic               have_pred, have_pred_n;
    logic [MATCH_W-1:0] match_cnt, match_cnt_n;
    logic [MISS_W-1:0]  miss_cnt, miss_cnt_n;
    logic               err_pulse_n;
    logic [CNT_W-1:0]   err_count_n;
    logic               zero_seen_n;

    function automatic logic [WIDTH-1:0] lfsr_next(input logic [WIDTH-1:0] x);
        return {x[WIDTH-2:0], ^(x & TAPS)};
    endfunction

    // State and output registers; all outputs come straight from flops.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= HUNT;
            pred      <= '0;
            have_pred <= 1'b0;
            match_cnt <= '0;
            miss_cnt  <= '0;
            err_pulse <= 1'b0;
            err_count <= '0;
            zero_seen <= 1'b0;
        end else begin
            state     <= state_n;
            pred      <= pred_n;
            have_pred <= have_pred_n;
            match_cnt <= match_cnt_n;
            miss_cnt  <= miss_cnt_n;
            err_pulse <= err_pulse_n;
            err_count <= err_count_n;
            zero_seen <= zero_seen_n;
        end
    end

    assign locked = (state == LOCKED);

    // Next-state: hunt/lock sequencing, prediction, error accounting.
    always_comb begin
        state_n     = state;
        pred_n      = pred;
        have_pred_n = have_pred;
        match_cnt_n = match_cnt;
        miss_cnt_n  = miss_cnt;
        err_pulse_n = 1'b0;
        err_count_n = err_count;
        zero_seen_n = zero_seen;

        if (din_valid) begin
            if (din == '0) begin
                zero_seen_n = 1'b1;
            end

            case (state)
                HUNT: begin
                    pred_n      = lfsr_next(din);
                    have_pred_n = 1'b1;
                    if (have_pred) begin
                        if ((din == pred) && (din != '0)) begin
                            match_cnt_n = match_cnt + MATCH_W'(1);
                        end else begin
                            match_cnt_n = '0;
                        end
                        if (match_cnt_n == MATCH_W'(LOCK_CNT)) begin
                            state_n     = LOCKED;
                            miss_cnt_n  = '0;
                            match_cnt_n = '0;
                        end
                    end
                end

                LOCKED: begin
                    // Flywheel: keep predicting from our own state, not the line.
                    pred_n = lfsr_next(pred);
                    if (din == pred) begin
                        miss_cnt_n = '0;
                    end else begin
                        err_pulse_n = 1'b1;
                        if (err_count != '1) begin
                            err_count_n = err_count + CNT_W'(1);
                        end
                        miss_cnt_n = miss_cnt + MISS_W'(1);
                        if (miss_cnt_n == MISS_W'(LOSS_CNT)) begin
                            state_n     = HUNT;
                            have_pred_n = 1'b0;
                            match_cnt_n = '0;
                            miss_cnt_n  = '0;
                        end
                    end
                end

                default: state_n = HUNT;
            endcase
        end

        // Clear has priority over a same-edge increment or zero detection.
        if (clr_err) begin
            err_count_n = '0;
            zero_seen_n = 1'b0;
        end
    end

endmodule

// File: tb/tb_lfsr_checker.sv
// Bench for lfsr_checker: directed link scenarios followed by randomized
// traffic, all compared against a sample-by-sample behavioural model.
module tb_lfsr_checker;

    localparam int LOCK_CNT = 3;
    localparam int LOSS_CNT = 3;
    localparam int CNT_MAX  = 255;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] din = 4'd0;
    logic       din_valid = 1'b0;
    logic       clr_err = 1'b0;
    logic       locked;
    logic       err_pulse;
    logic [7:0] err_count;
    logic       zero_seen;

    int n_checks = 0;
    int n_errors = 0;

    // behavioural model
    bit       m_locked;
    bit       m_have;
    int       m_pred;
    int       m_match;
    int       m_miss;
    bit       m_pulse;
    int       m_cnt;
    bit       m_zero;

    int       seq;
    int       pulses;

    lfsr_checker dut (
        .clk       (clk),
        .rst       (rst),
        .din       (din),
        .din_valid (din_valid),
        .clr_err   (clr_err),
        .locked    (locked),
        .err_pulse (err_pulse),
        .err_count (err_count),
        .zero_seen (zero_seen)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // x^4+x^3+1 successor written arithmetically
    function automatic int succ(input int x);
        return ((x * 2) % 16) + (((x / 8) + (x / 4)) % 2);
    endfunction

    task automatic model_reset();
        m_locked = 0; m_have = 0; m_pred = 0; m_match = 0;
        m_miss = 0; m_pulse = 0; m_cnt = 0; m_zero = 0;
    endtask

    task automatic model_step(input int d, input bit v, input bit c);
        m_pulse = 0;
        if (v) begin
            if (d == 0) m_zero = 1;
            if (!m_locked) begin
                if (m_have) begin
                    if (d == m_pred && d != 0) m_match++;
                    else m_match = 0;
                end
                m_pred = succ(d);
                m_have = 1;
                if (m_match == LOCK_CNT) begin
                    m_locked = 1; m_miss = 0; m_match = 0;
                end
            end else begin
                if (d == m_pred) m_miss = 0;
                else begin
                    m_pulse = 1;
                    if (m_cnt < CNT_MAX) m_cnt++;
                    m_miss++;
                end
                m_pred = succ(m_pred);
                if (m_miss == LOSS_CNT) begin
                    m_locked = 0; m_have = 0; m_match = 0; m_miss = 0;
                end
            end
        end
        if (c) begin
            m_cnt = 0; m_zero = 0;
        end
    endtask

    task automatic compare_all(input string tag);
        check({tag, ".locked"},    int'(locked),    int'(m_locked));
        check({tag, ".err_pulse"}, int'(err_pulse), int'(m_pulse));
        check({tag, ".err_count"}, int'(err_count), m_cnt);
        check({tag, ".zero_seen"}, int'(zero_seen), int'(m_zero));
    endtask

    task automatic cycle(input string tag, input int d, input bit v, input bit c);
        @(negedge clk);
        din       = d[3:0];
        din_valid = v;
        clr_err   = c;
        @(posedge clk);
        model_step(d, v, c);
        #1;
        compare_all(tag);
        if (err_pulse) pulses++;
    endtask

    task automatic send_good(input string tag);
        cycle(tag, seq, 1'b1, 1'b0);
        seq = succ(seq);
    endtask

    task automatic send_bad(input string tag, input int flip);
        cycle(tag, seq ^ flip, 1'b1, 1'b0);
        seq = succ(seq);
    endtask

    initial begin
        model_reset();
        #12;
        compare_all("reset");
        @(negedge clk);
        rst = 1'b1;

        // 1: lock from 1111,1110,1100,1000
        seq = 15;
        for (int i = 0; i < 4; i++) begin
            send_good("t1");
            if (i < 3) check("t1_not_yet", int'(locked), 0);
        end
        check("t1_locked", int'(locked), 1);
        check("t1_errcnt", int'(err_count), 0);

        // 2: a full period plus wrap back to 1111
        pulses = 0;
        for (int i = 0; i < 16; i++) send_good("t2");
        check("t2_pulses", pulses, 0);
        check("t2_locked", int'(locked), 1);
        check("t2_errcnt", int'(err_count), 0);

        // 3: single corrupted word 0010 -> 0011
        pulses = 0;
        while (seq != 2) send_good("t3_pre");
        send_bad("t3_bad", 1);
        check("t3_pulse", int'(err_pulse), 1);
        for (int i = 0; i < 5; i++) send_good("t3_post");
        check("t3_pulses", pulses, 1);
        check("t3_errcnt", int'(err_count), 1);
        check("t3_locked", int'(locked), 1);

        // 4: three consecutive wrong words drop lock, then relock
        cycle("t4_clr", 0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) send_bad("t4_bad", 6);
        check("t4_errcnt", int'(err_count), 3);
        check("t4_unlocked", int'(locked), 0);
        for (int i = 0; i < 1 + LOCK_CNT; i++) begin
            check("t4_relock_wait", int'(locked), 0);
            send_good("t4_relock");
        end
        check("t4_relocked", int'(locked), 1);

        // 5: zero detection, sticky, clear, clear racing a mismatch
        cycle("t5_zero", 0, 1'b1, 1'b0);
        check("t5_zero", int'(zero_seen), 1);
        for (int i = 0; i < 3; i++) cycle("t5_idle", 0, 1'b0, 1'b0);
        check("t5_sticky", int'(zero_seen), 1);
        cycle("t5_clr", 0, 1'b0, 1'b1);
        check("t5_cleared", int'(zero_seen), 0);
        // get back in step with the flywheel
        seq = m_pred;
        send_good("t5_sync");
        send_good("t5_sync");
        cycle("t5_clr_bad", seq ^ 8, 1'b1, 1'b1);
        seq = succ(seq);
        check("t5_clr_cnt", int'(err_count), 0);
        check("t5_clr_pulse", int'(err_pulse), 1);

        // 6: saturate the error counter
        if (!m_locked) begin
            for (int i = 0; i < 1 + LOCK_CNT; i++) send_good("t6_lock");
        end
        while (m_cnt < CNT_MAX && m_locked) begin
            send_bad("t6_bad", 1);
            send_good("t6_good");
        end
        check("t6_at_max", int'(err_count), CNT_MAX);
        send_bad("t6_over", 1);
        check("t6_sat", int'(err_count), CNT_MAX);
        check("t6_sat_pulse", int'(err_pulse), 1);

        // async reset between clock edges
        @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        model_reset();
        compare_all("async_rst");
        @(negedge clk);
        rst = 1'b1;
        compare_all("async_rst_hold");

        // randomized traffic with error injection, resyncs and clears
        seq = 1 + $urandom_range(14);
        for (int i = 0; i < 3000; i++) begin
            int r;
            int d;
            bit v;
            bit c;
            r = $urandom_range(99);
            v = ($urandom_range(3) != 0);
            c = ($urandom_range(39) == 0);
            d = seq;
            if (r < 8) d = seq ^ (1 + $urandom_range(14));
            else if (r < 10) d = 0;
            else if (r < 11) seq = 1 + $urandom_range(14);
            cycle("rand", d, v, c);
            if (v) seq = succ(seq);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
